// File: rtl/adel_imem_loader.sv
// adel_imem_loader
//
// Instruction-supply block for the adel core. A program is streamed in as
// bytes over a valid/ready handshake and stored in an internal instruction
// RAM. While that happens the core is held in reset. Once the last word is
// written the core is released and fetches instructions combinationally
// from the RAM by program counter.
//
// Stream format: one count byte N, then N 16-bit words, each sent as the
// low byte followed by the high byte. Word k lands at RAM address k.
//
// Ports
//   clk_i         system clock
//   nrst_i        asynchronous active-low reset
//   load_start_i  one-cycle pulse: abort whatever is going on, expect a count
//   load_valid_i  load_byte_i carries a byte
//   load_byte_i   program stream byte
//   load_ready_o  a byte is accepted this cycle (combinational, 0 in RUN)
//   pc_i          program counter from the core
//   inst_o        instruction at pc_i, or the NOP 0xE000 outside the program
//   core_nrst_o   registered active-low reset to the core
//   prog_len_o    number of words in the loaded program
//   err_o         sticky error: the last count byte exceeded DEPTH
//
// AW must equal clog2(DEPTH); the count byte is 8 bits, so DEPTH <= 255.

module adel_imem_loader #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk_i,
  input  logic          nrst_i,
  input  logic          load_start_i,
  input  logic          load_valid_i,
  input  logic [7:0]    load_byte_i,
  output logic          load_ready_o,
  input  logic [15:0]   pc_i,
  output logic [15:0]   inst_o,
  output logic          core_nrst_o,
  output logic [AW:0]   prog_len_o,
  output logic          err_o
);

  // OR r0,r0,#0 -- returned for every pc outside the loaded program.
  localparam logic [15:0] NOP_INST = 16'hE000;
  localparam logic [8:0]  DEPTH_B  = 9'(DEPTH);

  typedef enum logic [1:0] {
    ST_CNT = 2'd0,
    ST_LO  = 2'd1,
    ST_HI  = 2'd2,
    ST_RUN = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [7:0]     low_q, low_d;
  logic [AW:0]    len_q, len_d;
  logic           err_q, err_d;
  logic           core_nrst_q, core_nrst_d;

  logic           xfer;
  logic           mem_we;
  logic [15:0]    mem_wdata;
  logic           last_word;
  logic [15:0]    len_ext;

  // Instruction storage. Deliberately not reset: a reset mid-load keeps
  // whatever was already written, and prog_len=0 hides it from the core.
  logic [15:0]    mem_q [DEPTH];

  assign load_ready_o = (state_q != ST_RUN);
  assign xfer         = load_valid_i && load_ready_o;

  // Final word of the program is the one at address prog_len-1.
  assign last_word = ((AW+1)'(addr_q) == (len_q - (AW+1)'(1)));

  assign mem_wdata = {load_byte_i, low_q};

  // --------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    low_d       = low_q;
    len_d       = len_q;
    err_d       = err_q;
    mem_we      = 1'b0;
    // The core leaves reset one cycle after RUN is entered.
    core_nrst_d = (state_q == ST_RUN);

    if (load_start_i) begin
      // Restart wins over a byte arriving on the same edge; that byte is lost.
      state_d     = ST_CNT;
      addr_d      = '0;
      core_nrst_d = 1'b0;
    end else if (xfer) begin
      unique case (state_q)
        ST_CNT: begin
          if (load_byte_i == 8'd0) begin
            len_d   = '0;
            err_d   = 1'b0;
            state_d = ST_RUN;
          end else if ({1'b0, load_byte_i} > DEPTH_B) begin
            // Oversized program: flag it and wait for another count.
            err_d = 1'b1;
          end else begin
            len_d   = (AW+1)'(load_byte_i);
            err_d   = 1'b0;
            addr_d  = '0;
            state_d = ST_LO;
          end
        end
        ST_LO: begin
          low_d   = load_byte_i;
          state_d = ST_HI;
        end
        ST_HI: begin
          // Whole word written at once, so the core never sees half a word.
          mem_we = 1'b1;
          if (last_word) begin
            state_d = ST_RUN;
          end else begin
            addr_d  = addr_q + AW'(1);
            state_d = ST_LO;
          end
        end
        ST_RUN: begin
          // load_ready_o is 0 here, so no transfer can occur.
          state_d = ST_RUN;
        end
        default: state_d = ST_CNT;
      endcase
    end
  end

  // --------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q     <= ST_CNT;
      addr_q      <= '0;
      low_q       <= '0;
      len_q       <= '0;
      err_q       <= 1'b0;
      core_nrst_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      low_q       <= low_d;
      len_q       <= len_d;
      err_q       <= err_d;
      core_nrst_q <= core_nrst_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[addr_q] <= mem_wdata;
    end
  end

  // --------------------------------------------------------------------
  // Instruction read: full 16-bit compare, so wrapped negative targets and
  // anything at or beyond DEPTH fall out as the NOP.
  // --------------------------------------------------------------------
  assign len_ext = 16'(len_q);
  assign inst_o  = (pc_i < len_ext) ? mem_q[pc_i[AW-1:0]] : NOP_INST;

  assign core_nrst_o = core_nrst_q;
  assign prog_len_o  = len_q;
  assign err_o       = err_q;

endmodule
